air_hockey_core_p: RTL
======================

Name: air_hockey_core_p

Overview:
Parametrised air-hockey game controller for a two-player, button-driven table. Owns puck position, wall reflection, serve/return timing, scoring and win detection on an X_MAX+1 by Y_MAX+1 field. All game timing advances on an external `tick` strobe, so one RTL serves both simulation (tick every cycle) and board use (tick from a prescaler). Outputs drive the LED/SSD display layer; buttons arrive already debounced as single-cycle pulses.

Parameters:
CW, 3, coordinate width in bits
X_MAX, 7, last column; A's goal line is X=0, B's goal line is X=X_MAX (X_MAX >= 2)
Y_MAX, 4, last row (Y_MAX < 2^CW - 1)
SW, 2, score width in bits
WIN_SCORE, 3, score that ends the game (must be < 2^SW)
WAIT_TICKS, 2, ticks per display/goal/game-over phase, per puck step, and per response window (>= 1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
tick  in  1  timing strobe, one-cycle pulse
BTN_A  in  1  player A button pulse
BTN_B  in  1  player B button pulse
DIR_A  in  2  A shot direction: 00 straight, 01 up (+Y), 10 down (-Y), 11 treated as 00
DIR_B  in  2  B shot direction, same encoding as DIR_A
Y_in_A  in  CW  A paddle row
Y_in_B  in  CW  B paddle row
X_COORD  out  CW  puck column
Y_COORD  out  CW  puck row
score_a  out  SW  A score
score_b  out  SW  B score
state_o  out  4  current state encoding
turn  out  2  01 = A serves, 10 = B serves, 00 = none
winner  out  2  01 = A won, 10 = B won, 00 = none

Behaviour:
- Reset: state IDLE. All outputs 0. Internal dirY = 00, timer = 0. Reset is asynchronous and aborts any state, including mid-flight.
- State encoding: IDLE 0, DISPLAY 1, HIT_A 2, HIT_B 3, SEND_A 4, SEND_B 5, RESP_A 6, RESP_B 7, GOAL_A 8, GOAL_B 9, GAME_OVER 10.
- Phase counting: timer counts ticks. A phase "expires" on the tick where timer == WAIT_TICKS-1; timer then returns to 0. With tick low, timer and all positions hold. Every state transition clears timer.
- Y step: done once per step using dirY.
  - dirY 01: if Y==Y_MAX then Y-1 and dirY becomes 10, else Y+1.
  - dirY 10: if Y==0 then Y+1 and dirY becomes 01, else Y-1.
  - dirY 00: Y holds.
- IDLE: on BTN_A, turn=01 and go to DISPLAY; else on BTN_B, turn=10 and go to DISPLAY. If both are pressed, A has priority. winner is cleared on leaving IDLE.
- DISPLAY: on expiry, go to HIT_A if turn==01, else HIT_B.
- HIT_A: on BTN_A with Y_in_A<=Y_MAX, set X=0, Y=Y_in_A, dirY=DIR_A (11 maps to 00), then go to SEND_B. Out-of-range Y_in_A is ignored. No timeout.
- HIT_B: mirror of HIT_A with X=X_MAX, then go to SEND_A.
- SEND_B: on each expiry, do a Y step and X+1. When the new X == X_MAX, go to RESP_B.
- SEND_A: mirror of SEND_B with X-1, ending at X == 0 and going to RESP_A.
- RESP_B: open for one WAIT_TICKS window.
  - On BTN_B with Y_in_B==Y: X=X_MAX-1, dirY=DIR_B (11 maps to 00), apply one Y step with the new dirY, then go to SEND_A.
  - A press with a mismatched row is ignored.
  - On expiry with no hit: score_a+1, go to GOAL_A.
  - A hit on the same cycle as expiry counts as a hit.
- RESP_A: mirror of RESP_B; X becomes 1 on a hit, and score_b increments on a miss.
- GOAL_A: on expiry, if score_a==WIN_SCORE then winner=01, turn=00, go to GAME_OVER. Otherwise turn=10 and go to HIT_B (conceding player serves).
- GOAL_B: mirror of GOAL_A (winner=10, or turn=01 and go to HIT_A).
- GAME_OVER: on expiry, clear scores, X and Y, then go to IDLE. winner holds until the next serve press.
- Buttons in states not listed above have no effect.
- Scores never wrap, because the game ends at WIN_SCORE.

Test Plan:
(Defaults, tick=1 every cycle unless stated.)
1. Serve bounce. BTN_A with Y_in_A=2, DIR_A=01 in IDLE, then again in HIT_A → SEND_B steps every 2 cycles through (1,3) (2,4) (3,3) (4,2) (5,1) (6,0) (7,1), then RESP_B with dirY=01.
2. Return. In RESP_B at (7,1), BTN_B with Y_in_B=1, DIR_B=10 → X=6, Y=0, dirY=10, state SEND_A. A BTN_B press with Y_in_B=3 instead is ignored.
3. Miss. No BTN_B for 2 ticks in RESP_B → score_a=1, GOAL_A for 2 ticks, then HIT_B with turn=10.
4. Win. Drive A to 3 goals → GAME_OVER with winner=01; after 2 ticks, IDLE with scores=0 and X=Y=0. Tick held low for 10 cycles in any state → no change.
5. Priority and validity. BTN_A and BTN_B in the same IDLE cycle → turn=01. HIT_A with Y_in_A=5 → no serve. DIR_A=11 → Y constant during flight.
6. Mid-flight reset. Assert rst during SEND_A with no clock edge → all outputs 0 and state IDLE immediately. After release, normal serve works.

Source files
------------

// File: rtl/air_hockey_core_p.sv
// Two-player air-hockey game controller: puck flight, wall bounce, serve/return
// windows, scoring and win detection, all paced by an external tick strobe.
module air_hockey_core_p #(
  parameter int CW         = 3,
  parameter int X_MAX      = 7,
  parameter int Y_MAX      = 4,
  parameter int SW         = 2,
  parameter int WIN_SCORE  = 3,
  parameter int WAIT_TICKS = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          BTN_A,
  input  logic          BTN_B,
  input  logic [1:0]    DIR_A,
  input  logic [1:0]    DIR_B,
  input  logic [CW-1:0] Y_in_A,
  input  logic [CW-1:0] Y_in_B,
  output logic [CW-1:0] X_COORD,
  output logic [CW-1:0] Y_COORD,
  output logic [SW-1:0] score_a,
  output logic [SW-1:0] score_b,
  output logic [3:0]    state_o,
  output logic [1:0]    turn,
  output logic [1:0]    winner
);
  localparam int TW = $clog2(WAIT_TICKS + 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, DISPLAY = 4'd1, HIT_A = 4'd2, HIT_B = 4'd3,
    SEND_A = 4'd4, SEND_B = 4'd5, RESP_A = 4'd6, RESP_B = 4'd7,
    GOAL_A = 4'd8, GOAL_B = 4'd9, GAME_OVER = 4'd10
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [1:0]      dir_y, dir_n;
  logic [CW-1:0]   x_n, y_n;
  logic [SW-1:0]   sa_n, sb_n;
  logic [1:0]      turn_n, win_n;
  logic            expire;

  // Shot direction 11 is treated as straight.
  function automatic logic [1:0] dmap(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  // One vertical step with reflection at the walls; returns {dir, y}.
  function automatic logic [CW+1:0] ystep(input logic [CW-1:0] y, input logic [1:0] d);
    case (d)
      2'b01:   return (y == CW'(Y_MAX)) ? {2'b10, y - CW'(1)} : {2'b01, y + CW'(1)};
      2'b10:   return (y == '0)         ? {2'b01, y + CW'(1)} : {2'b10, y - CW'(1)};
      default: return {d, y};
    endcase
  endfunction

  assign state_o = state;

  always_comb begin
    state_n = state;
    timer_n = timer;
    x_n     = X_COORD;
    y_n     = Y_COORD;
    dir_n   = dir_y;
    sa_n    = score_a;
    sb_n    = score_b;
    turn_n  = turn;
    win_n   = winner;
    expire  = tick && (timer == TW'(WAIT_TICKS - 1));
    if (tick && !(state inside {IDLE, HIT_A, HIT_B}))
      timer_n = expire ? '0 : timer + TW'(1);
    case (state)
      IDLE: begin
        if (BTN_A) begin
          turn_n = 2'b01; win_n = 2'b00; state_n = DISPLAY;
        end else if (BTN_B) begin
          turn_n = 2'b10; win_n = 2'b00; state_n = DISPLAY;
        end
      end
      DISPLAY: if (expire) state_n = (turn == 2'b01) ? HIT_A : HIT_B;
      HIT_A: begin
        if (BTN_A && Y_in_A <= CW'(Y_MAX)) begin
          x_n = '0; y_n = Y_in_A; dir_n = dmap(DIR_A); state_n = SEND_B;
        end
      end
      HIT_B: begin
        if (BTN_B && Y_in_B <= CW'(Y_MAX)) begin
          x_n = CW'(X_MAX); y_n = Y_in_B; dir_n = dmap(DIR_B); state_n = SEND_A;
        end
      end
      SEND_B: begin
        if (expire) begin
          {dir_n, y_n} = ystep(Y_COORD, dir_y);
          x_n = X_COORD + CW'(1);
          if (X_COORD == CW'(X_MAX - 1)) state_n = RESP_B;
        end
      end
      SEND_A: begin
        if (expire) begin
          {dir_n, y_n} = ystep(Y_COORD, dir_y);
          x_n = X_COORD - CW'(1);
          if (X_COORD == CW'(1)) state_n = RESP_A;
        end
      end
      // A hit wins over a window expiring on the same cycle.
      RESP_B: begin
        if (BTN_B && Y_in_B == Y_COORD) begin
          x_n = CW'(X_MAX - 1);
          {dir_n, y_n} = ystep(Y_COORD, dmap(DIR_B));
          state_n = SEND_A;
        end else if (expire) begin
          sa_n = score_a + SW'(1); state_n = GOAL_A;
        end
      end
      RESP_A: begin
        if (BTN_A && Y_in_A == Y_COORD) begin
          x_n = CW'(1);
          {dir_n, y_n} = ystep(Y_COORD, dmap(DIR_A));
          state_n = SEND_B;
        end else if (expire) begin
          sb_n = score_b + SW'(1); state_n = GOAL_B;
        end
      end
      GOAL_A: begin
        if (expire) begin
          if (score_a == SW'(WIN_SCORE)) begin
            win_n = 2'b01; turn_n = 2'b00; state_n = GAME_OVER;
          end else begin
            turn_n = 2'b10; state_n = HIT_B;
          end
        end
      end
      GOAL_B: begin
        if (expire) begin
          if (score_b == SW'(WIN_SCORE)) begin
            win_n = 2'b10; turn_n = 2'b00; state_n = GAME_OVER;
          end else begin
            turn_n = 2'b01; state_n = HIT_A;
          end
        end
      end
      GAME_OVER: begin
        if (expire) begin
          sa_n = '0; sb_n = '0; x_n = '0; y_n = '0; state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) timer_n = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      dir_y   <= 2'b00;
      X_COORD <= '0;
      Y_COORD <= '0;
      score_a <= '0;
      score_b <= '0;
      turn    <= 2'b00;
      winner  <= 2'b00;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      dir_y   <= dir_n;
      X_COORD <= x_n;
      Y_COORD <= y_n;
      score_a <= sa_n;
      score_b <= sb_n;
      turn    <= turn_n;
      winner  <= win_n;
    end
  end
endmodule
